// File: rtl/overlay_fetch_ctrl.sv
// overlay_fetch_ctrl
// Sequences SDRAM channel 1, which is shared by overlay download writes and
// display-time overlay reads. Download bytes are paired into 16-bit words and
// written. During display, 32-bit words (two RGBA4444 pixels each) are
// prefetched into a small FIFO. One pixel is delivered per active ce_pix.
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   ce_pix, hblank, vblank pixel enable and video timing (vblank rise = frame start)
//   sdram_ok              SDRAM fitted
//   rom_dl, bg_dl         cartridge / overlay download active
//   dl_wr, dl_addr, dl_data  download byte stream
//   sd_addr, sd_din, sd_rnw, sd_req  SDRAM request (stable while sd_req=1)
//   sd_ack, sd_dout       SDRAM completion pulse and read data
//   pix_rgba              {a,b,g,r} overlay pixel
//   use_bg                overlay valid and in use
//   underrun, dl_overrun  sticky error flags

module overlay_fetch_ctrl #(
    parameter int AW         = 24,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic          hblank,
    input  logic          vblank,
    input  logic          sdram_ok,
    input  logic          rom_dl,
    input  logic          bg_dl,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [7:0]    dl_data,
    output logic [AW-1:0] sd_addr,
    output logic [15:0]   sd_din,
    output logic          sd_rnw,
    output logic          sd_req,
    input  logic          sd_ack,
    input  logic [31:0]   sd_dout,
    output logic [15:0]   pix_rgba,
    output logic          use_bg,
    output logic          underrun,
    output logic          dl_overrun
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] sd_addr_q, sd_addr_d;
    logic [15:0]   sd_din_q, sd_din_d;
    logic          sd_rnw_q, sd_rnw_d;
    logic          use_bg_q, use_bg_d;
    logic [7:0]    low_byte_q, low_byte_d;
    logic          wr_pend_q, wr_pend_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          half_q, half_d;
    logic [15:0]   pix_q, pix_d;
    logic          underrun_q, underrun_d;
    logic          dl_overrun_q, dl_overrun_d;
    logic          vblank_q, vblank_d;
    logic          armed_q, armed_d;
    logic          epoch_q, epoch_d;
    logic          rd_epoch_q, rd_epoch_d;
    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [31:0]   fifo_d [FIFO_DEPTH];

    logic          frame_start;
    logic          wr_busy;
    logic          push;
    logic          pop;
    logic          pix_act;
    logic          rd_ok;
    logic [31:0]   head;

    always_comb begin
        state_d      = state_q;
        sd_addr_d    = sd_addr_q;
        sd_din_d     = sd_din_q;
        sd_rnw_d     = sd_rnw_q;
        use_bg_d     = use_bg_q;
        low_byte_d   = low_byte_q;
        wr_pend_d    = wr_pend_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_addr_d    = rd_addr_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        half_d       = half_q;
        pix_d        = pix_q;
        underrun_d   = underrun_q;
        dl_overrun_d = dl_overrun_q;
        vblank_d     = vblank_q;
        armed_d      = armed_q;
        epoch_d      = epoch_q;
        rd_epoch_d   = rd_epoch_q;
        fifo_d       = fifo_q;
        pop          = 1'b0;
        head         = fifo_q[rptr_q];

        frame_start = ce_pix & vblank & ~vblank_q;
        if (ce_pix) begin
            vblank_d = vblank;
        end

        if (rom_dl) begin
            use_bg_d = 1'b0;
        end else if (bg_dl & sdram_ok) begin
            use_bg_d = 1'b1;
        end

        // A write finishing this cycle frees the slot for a new odd byte.
        wr_busy = wr_pend_q & ~((state_q == WR) & sd_ack);
        if ((state_q == WR) && sd_ack) begin
            wr_pend_d = 1'b0;
        end
        if (dl_wr && !dl_addr[0]) begin
            low_byte_d = dl_data;
        end
        if (dl_wr && dl_addr[0]) begin
            if (wr_busy) begin
                dl_overrun_d = 1'b1;
            end else begin
                wr_pend_d = 1'b1;
                wr_addr_d = dl_addr[AW:1];
                wr_data_d = {dl_data, low_byte_q};
            end
        end

        // Reads issued before the last flush carry the old epoch and are dropped.
        push = (state_q == RD) & sd_ack & (rd_epoch_q == epoch_q) & ~frame_start;

        pix_act = ce_pix & ~hblank & ~vblank & use_bg_q & ~bg_dl;
        if (pix_act) begin
            if (count_q != '0) begin
                pix_d  = half_q ? head[31:16] : head[15:0];
                half_d = ~half_q;
                pop    = half_q;
            end else begin
                pix_d      = '0;
                underrun_d = 1'b1;
            end
        end else if (!use_bg_q || bg_dl) begin
            pix_d = '0;
        end

        if (push) begin
            fifo_d[wptr_q] = sd_dout;
            wptr_d         = wptr_q + PW'(1);
            rd_addr_d      = rd_addr_q + AW'(2);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (frame_start) begin
            count_d   = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            half_d    = 1'b0;
            rd_addr_d = '0;
            armed_d   = 1'b1;
            epoch_d   = ~epoch_q;
        end

        rd_ok = use_bg_q & ~bg_dl & (count_q < CW'(FIFO_DEPTH)) & armed_q & ~frame_start;

        case (state_q)
            IDLE: begin
                if (wr_pend_q) begin
                    state_d   = WR;
                    sd_addr_d = wr_addr_q;
                    sd_din_d  = wr_data_q;
                    sd_rnw_d  = 1'b0;
                end else if (rd_ok) begin
                    state_d    = RD;
                    sd_addr_d  = rd_addr_q;
                    sd_rnw_d   = 1'b1;
                    rd_epoch_d = epoch_q;
                end
            end
            WR, RD: begin
                if (sd_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sd_addr_q    <= '0;
            sd_din_q     <= '0;
            sd_rnw_q     <= 1'b1;
            use_bg_q     <= 1'b0;
            low_byte_q   <= '0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_addr_q    <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            half_q       <= 1'b0;
            pix_q        <= '0;
            underrun_q   <= 1'b0;
            dl_overrun_q <= 1'b0;
            vblank_q     <= 1'b0;
            armed_q      <= 1'b0;
            epoch_q      <= 1'b0;
            rd_epoch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sd_addr_q    <= sd_addr_d;
            sd_din_q     <= sd_din_d;
            sd_rnw_q     <= sd_rnw_d;
            use_bg_q     <= use_bg_d;
            low_byte_q   <= low_byte_d;
            wr_pend_q    <= wr_pend_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_addr_q    <= rd_addr_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            half_q       <= half_d;
            pix_q        <= pix_d;
            underrun_q   <= underrun_d;
            dl_overrun_q <= dl_overrun_d;
            vblank_q     <= vblank_d;
            armed_q      <= armed_d;
            epoch_q      <= epoch_d;
            rd_epoch_q   <= rd_epoch_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign sd_req     = (state_q != IDLE);
    assign sd_addr    = sd_addr_q;
    assign sd_din     = sd_din_q;
    assign sd_rnw     = sd_rnw_q;
    assign pix_rgba   = pix_q;
    assign use_bg     = use_bg_q;
    assign underrun   = underrun_q;
    assign dl_overrun = dl_overrun_q;

endmodule

// File: doc/overlay_fetch_ctrl.md
Name: overlay_fetch_ctrl

Overview:
Sequences the SDRAM channel-1 port shared between overlay download writes and display-time overlay reads. Pairs ioctl bytes into 16-bit words and writes them. Prefetches 32-bit words (two RGBA4444 pixels each) into a 2-entry FIFO and delivers one pixel per active ce_pix to the alpha-blend/colour path.

Parameters:
AW, 24, SDRAM word address width (16-bit units)
FIFO_DEPTH, 2, prefetch FIFO depth in 32-bit words (power of 2, fixed 2 for this build)

Ports:
clk  in  1  system clock (48 MHz pixel-domain clock)
reset_n  in  1  synchronous reset, active low
ce_pix  in  1  pixel clock enable
hblank  in  1  horizontal blank
vblank  in  1  vertical blank; rising edge = frame start
sdram_ok  in  1  SDRAM fitted (sdram_sz[2:0] != 0)
rom_dl  in  1  cartridge download active
bg_dl  in  1  overlay download active
dl_wr  in  1  download byte strobe
dl_addr  in  25  download byte address
dl_data  in  8  download byte
sd_addr  out  AW  SDRAM word address
sd_din  out  16  SDRAM write data
sd_rnw  out  1  1=read, 0=write
sd_req  out  1  request, level, held until sd_ack
sd_ack  in  1  one-cycle completion; sd_dout valid this cycle on reads
sd_dout  in  32  read data, low half = lower address pixel
pix_rgba  out  16  {a,b,g,r} 4 bits each
use_bg  out  1  overlay valid and in use
underrun  out  1  sticky: pixel wanted with FIFO empty
dl_overrun  out  1  sticky: odd byte arrived while write pending

Behaviour:
- Reset (reset_n=0 on clk edge): sd_req=0, sd_rnw=1, sd_addr=0, sd_din=0, pix_rgba=0, use_bg=0, underrun=0, dl_overrun=0, FIFO empty, state IDLE. Applies mid-transaction; sd_req drops in the same cycle.
- use_bg: cleared by rom_dl; set while bg_dl & sdram_ok. rom_dl wins if both are high.
- Download path: dl_wr with dl_addr[0]=0 latches the low byte. dl_wr with dl_addr[0]=1 queues a write: sd_din={dl_data,low}, sd_addr=dl_addr[AW:1], sd_rnw=0. If a write is still pending, the new write is dropped and dl_overrun is set.
- States: IDLE, WR (sd_req=1, rnw=0), RD (sd_req=1, rnw=1).
- IDLE->WR when a write is queued. Writes have priority over reads.
- IDLE->RD when use_bg & ~bg_dl & FIFO not full & frame armed.
- WR/RD return to IDLE on sd_ack. On RD ack, sd_dout is pushed to the FIFO and the read address increments by 2.
- Request signals (sd_addr, sd_din, sd_rnw) are stable while sd_req=1.
- A read in flight when bg_dl rises completes normally; its data is then discarded by the flush below.
- Frame start (registered vblank rising edge, sampled on ce_pix):
  - FIFO flushed, pixel half-select=0, read address=0, frame armed.
  - A read in flight completes, but its data is discarded because it was tagged with the pre-flush epoch.
- Pixel output, on ce_pix & ~hblank & ~vblank & use_bg & ~bg_dl:
  - FIFO non-empty: pix_rgba <= head[15:0] when half=0, head[31:16] when half=1. Toggle half; pop the head after half=1.
  - FIFO empty: pix_rgba <= 0, underrun <= 1, half unchanged (stream stalls, no skip).
- Output latency: pix_rgba updates on the clk edge of the qualifying ce_pix cycle.
- When the output condition is false, pix_rgba <= 0 if ~use_bg | bg_dl; otherwise it holds its value (blanking).
- Simultaneous push and pop in the same cycle are both honoured, so occupancy is unchanged. Full FIFO blocks new reads only.
- Address wraps modulo 2^AW silently.

Test Plan:
- Reset: hold reset_n=0 with sd_req=1 mid-read, release -> sd_req=0, pix_rgba=0, use_bg=0, both flags 0 on the first cycle.
- Download pairing: bg_dl=1, sdram_ok=1, bytes 0x34@0, 0x12@1 -> one write, sd_addr=0, sd_din=0x1234, rnw=0. use_bg=1. Ack after 3 cycles -> IDLE.
- Overrun: odd byte at address 3 while the write for address 1 is unacked -> dl_overrun=1, only one write issued.
- Frame fetch:
  - Stimulus: vblank rising edge, sd_ack returns 0xBBBBAAAA then 0xDDDDCCCC.
  - Reads issued: two, at addresses 0 and 2, then the request stops (FIFO full).
  - First 4 active ce_pix -> pix_rgba = AAAA, BBBB, CCCC, DDDD. A third read is issued after the first pop.
- Underrun: withhold sd_ack across active pixels -> pix_rgba=0, underrun=1. After the ack, the next ce_pix outputs the low half of that word.
- Arbitration/flush:
  - Read pending when bg_dl rises and an odd byte arrives: write issues after the read ack, read data is discarded, no further reads while bg_dl=1.
  - rom_dl pulse -> use_bg=0, pix_rgba=0.
